lsu_axi_master: RTL
===================

Name: lsu_axi_master

Overview:
- Load/store unit bus master between the execute stage (upstream) and the data-side SRAM/AXI-lite slave (downstream).
- Accepts one memory request at a time from EXU via valid/ready.
- Drives the AXI-lite read (AR/R) or write (AW/W/B) channels to the slave.
- Aligns, extracts and sign/zero-extends load data; returns a single response to WBU via valid/ready.

Parameters:
- ADDR_W, 32, address width of request and AXI address channels
- DATA_W, 32, data width; only 32 supported (4 byte lanes)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  LSU can accept request
- req_wen  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_signed  in  1  sign-extend loads when 1
- resp_valid  out  1  response valid to WBU
- resp_ready  in  1  WBU accepts response
- resp_rdata  out  DATA_W  extended load data (0 for stores/errors)
- resp_err  out  1  misaligned, illegal size, or bus error
- m_araddr  out  ADDR_W; m_arvalid  out  1; m_arready  in  1
- m_rdata  in  DATA_W; m_rresp  in  2; m_rvalid  in  1; m_rready  out  1
- m_awaddr  out  ADDR_W; m_awvalid  out  1; m_awready  in  1
- m_wdata  out  DATA_W; m_wstrb  out  4; m_wvalid  out  1; m_wready  in  1
- m_bresp  in  2; m_bvalid  in  1; m_bready  out  1

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
- On reset:
  - state=IDLE; all valid/ready outputs 0 except req_ready=1.
  - resp_rdata=0, resp_err=0.
  - m_araddr/m_awaddr/m_wdata=0, m_wstrb=0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - req_ready=1; on req_valid, latch addr/wdata/size/signed/wen.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]!=0) or size=3: RESP with err=1, no bus traffic.
  - Otherwise load goes to RD_ADDR, store goes to WR_REQ.
- RD_ADDR: m_arvalid=1, m_araddr=latched addr (unaligned low bits passed as-is); held stable until m_arready; then RD_DATA.
- RD_DATA:
  - m_rready=1; on m_rvalid, capture and extract, go RESP.
  - Byte lane = m_rdata[8*a+7:8*a] with a=addr[1:0]; half = m_rdata[16*addr[1]+15:16*addr[1]].
  - Extend by req_signed; err=(m_rresp!=0).
- WR_REQ:
  - m_awvalid and m_wvalid both asserted on entry; each deasserts independently after its own handshake.
  - Same-cycle AW and W handshakes allowed. Leave only when both are done, then go to WR_RESP.
  - m_wdata: byte replicated to all 4 lanes, half replicated to both halves, word as-is.
  - m_wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111.
- WR_RESP: m_bready=1; on m_bvalid, err=(m_bresp!=0); go RESP; resp_rdata=0.
- RESP:
  - resp_valid=1; resp_rdata/resp_err stable until resp_ready.
  - On resp_ready, go IDLE and resp_valid=0 next cycle; no new request accepted in that same cycle.
- Latency, zero-wait slave:
  - Load: accept→arvalid +1, →RESP +3 cycles.
  - Store: accept→RESP +3 cycles.
- Unknown state decodes to IDLE.
- Reset mid-transaction drops all valids immediately; the outstanding AXI beat is abandoned.

Optional Feature:
LSU_PERF_CNT_EN
- Defined: adds outputs perf_ld_cnt[31:0], perf_st_cnt[31:0], perf_stall_cnt[31:0], reset to 0.
  - ld/st counters increment on each completed RESP handshake of that type, errors included.
  - stall counter increments every cycle in RD_ADDR/RD_DATA/WR_REQ/WR_RESP where the awaited handshake does not complete.
  - All counters wrap at 2^32.
- Undefined: ports and logic absent.

Test Plan:
- Load word at 0x80000004, slave returns 0xDEADBEEF with zero wait → araddr=0x80000004, resp_rdata=0xDEADBEEF, err=0, resp_valid 3 cycles after accept.
- Load byte signed at 0x80000003, rdata=0x80FF7F01 → resp_rdata=0xFFFFFF80; unsigned → 0x00000080.
- Store half 0x1234 at 0x80000002 → wdata=0x12341234, wstrb=4'b1100; awready 2 cycles before wready still produces one B, err=0.
- Load word at 0x80000002 → no arvalid ever asserted, resp_valid next cycle with err=1, resp_rdata=0.
- Store with bresp=2'b10 and resp_ready held low 5 cycles → resp_valid/err=1 held stable 5 cycles, req_ready=0 throughout.
- Assert rst during RD_DATA → all AXI valids/readies 0 asynchronously, req_ready=1, state IDLE.

Source files
------------

// File: rtl/lsu_axi_master.sv
// Load/store unit master: one EXU request at a time onto AXI-lite, load data extraction/extension.
// Optional performance counters are enabled by defining LSU_PERF_CNT_EN.
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef LSU_PERF_CNT_EN
    output logic [31:0]       perf_ld_cnt,
    output logic [31:0]       perf_st_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic              aw_done_q, w_done_q;
    logic              aw_hs, w_hs;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = (a != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] align_wdata(input logic [DATA_W-1:0] d,
                                                      input logic [1:0] size);
        case (size)
            2'd0:    align_wdata = {4{d[7:0]}};
            2'd1:    align_wdata = {2{d[15:0]}};
            default: align_wdata = d;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    lane_strb = 4'b0001 << a;
            2'd1:    lane_strb = a[1] ? 4'b1100 : 4'b0011;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                      input logic [1:0] size,
                                                      input logic [1:0] a,
                                                      input logic sext);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = d[8*a +: 8];
        h = d[16*a[1] +: 16];
        case (size)
            2'd0:    load_extend = sext ? DATA_W'(b) : {{(DATA_W-8){1'b0}}, b};
            2'd1:    load_extend = sext ? DATA_W'(h) : {{(DATA_W-16){1'b0}}, h};
            default: load_extend = d;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Handshake outputs are decoded from state so reset drops them without a clock edge.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        resp_valid = 1'b0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned(req_size, req_addr[1:0])) state_d = RESP;
                    else if (req_wen)                        state_d = WR_REQ;
                    else                                     state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) state_d = RESP;
            end
            WR_REQ: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                aw_hs     = m_awvalid && m_awready;
                w_hs      = m_wvalid && m_wready;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
            end
            WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == WR_REQ) begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
        end else begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            size_q     <= 2'd0;
            sext_q     <= 1'b0;
            m_wdata    <= '0;
            m_wstrb    <= 4'b0000;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    addr_q     <= req_addr;
                    size_q     <= req_size;
                    sext_q     <= req_signed;
                    m_wdata    <= align_wdata(req_wdata, req_size);
                    m_wstrb    <= lane_strb(req_size, req_addr[1:0]);
                    resp_rdata <= '0;
                    resp_err   <= misaligned(req_size, req_addr[1:0]);
                end
                RD_DATA: if (m_rvalid) begin
                    resp_err   <= (m_rresp != 2'b00);
                    resp_rdata <= (m_rresp != 2'b00) ? '0
                                : load_extend(m_rdata, size_q, addr_q[1:0], sext_q);
                end
                WR_RESP: if (m_bvalid) begin
                    resp_err   <= (m_bresp != 2'b00);
                    resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    assign m_araddr = addr_q;
    assign m_awaddr = addr_q;

`ifdef LSU_PERF_CNT_EN
    logic wen_q;
    logic stall;

    always_comb begin
        stall = 1'b0;
        case (state_q)
            RD_ADDR: stall = !m_arready;
            RD_DATA: stall = !m_rvalid;
            WR_REQ:  stall = (state_d == WR_REQ);
            WR_RESP: stall = !m_bvalid;
            default: stall = 1'b0;
        endcase
    end

    // Counters wrap naturally at 2^32; errored requests still count by type.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q          <= 1'b0;
            perf_ld_cnt    <= 32'd0;
            perf_st_cnt    <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (state_q == IDLE && req_valid) wen_q <= req_wen;
            if (state_q == RESP && resp_ready) begin
                if (wen_q) perf_st_cnt <= perf_st_cnt + 32'd1;
                else       perf_ld_cnt <= perf_ld_cnt + 32'd1;
            end
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
